spi_slave_rx: RTL and testbench

- SPI slave endpoint: the downstream stage that consumes the SPI master's sclk/mosi serial stream and returns miso.
- Oversamples the SPI pins in the system clk domain, deserialises MSB-first bytes onto a parallel strobe interface, and serialises a host-supplied reply byte.
- SPI mode 0, 8-bit frames, multiple back-to-back bytes allowed per ss_n assertion.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave_rx.sv | 177 +++++++++++++++++
 tb/tb_spi_slave_rx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receiver: frame width, idle reply byte
// and the select-state encoding.
package spi_pkg;

   localparam int SPI_DW = 8;
   localparam logic [SPI_DW-1:0] SPI_TX_IDLE = 8'h00;

   typedef enum logic {
      SPI_IDLE,
      SPI_ACTIVE
   } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser for an asynchronous pin, followed by a delay flop that
// turns the synchronised level into single-cycle rise/fall strobes.
module spi_sync_edge #(
   parameter int   STAGES    = 2,
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] ff;
   logic              dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         ff  <= {STAGES{RESET_VAL}};
         dly <= RESET_VAL;
      end else begin
         ff  <= {ff[STAGES-2:0], din};
         dly <= ff[STAGES-1];
      end
   end

   assign sync = ff[STAGES-1];
   assign rise = sync & ~dly;
   assign fall = ~sync & dly;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversamples sclk/mosi/ss_n in the clk domain, assembles
// MSB-first bytes onto an rx strobe and shifts a host-supplied reply onto miso.
module spi_slave_rx
   import spi_pkg::*;
#(
   parameter int              DW          = SPI_DW,
   parameter logic [DW-1:0]   TX_IDLE     = DW'(SPI_TX_IDLE),
   parameter int              SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ss_n,
   input  logic          sclk,
   input  logic          mosi,
   output logic          miso,
   output logic          miso_oe,
   input  logic [DW-1:0] tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic [DW-1:0] rx_data,
   output logic          rx_valid,
   output logic          frame_err,
   output logic          busy
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   logic sclk_s, sclk_rise, sclk_fall;
   logic ss_n_s, ss_rise, ss_fall;
   logic mosi_s;

   logic [SYNC_STAGES-1:0] mosi_ff;

   spi_state_t state, state_next;

   logic [CW-1:0] bit_cnt;
   logic [DW-1:0] rx_sh;
   logic [DW-1:0] tx_sh;
   logic [DW-1:0] hold;
   logic          hold_full;
   logic [DW-1:0] presel;
   logic          load_pending;

   // Reply byte for a new frame or the next byte: the holding register if the
   // host filled it, otherwise the idle pattern.
   function automatic logic [DW-1:0] pick_tx(input logic full, input logic [DW-1:0] held);
      return full ? held : TX_IDLE;
   endfunction

   spi_sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b0)
   ) u_sclk_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (sclk),
      .sync (sclk_s),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(
      .STAGES    (SYNC_STAGES),
      .RESET_VAL (1'b1)
   ) u_ss_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (ss_n),
      .sync (ss_n_s),
      .rise (ss_rise),
      .fall (ss_fall)
   );

   // mosi only needs the same delay as sclk so data lines up with the rise strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         mosi_ff <= '0;
      end else begin
         mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], mosi};
      end
   end

   assign mosi_s = mosi_ff[SYNC_STAGES-1];

   logic unused_edges;
   assign unused_edges = &{1'b0, sclk_s, ss_rise};

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= SPI_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         SPI_IDLE:   if (ss_fall) state_next = SPI_ACTIVE;
         SPI_ACTIVE: if (ss_n_s)  state_next = SPI_IDLE;
         default:    state_next = SPI_IDLE;
      endcase
   end

   always_comb begin
      miso_oe  = (state == SPI_ACTIVE);
      miso     = (state == SPI_ACTIVE) ? tx_sh[DW-1] : 1'b0;
      busy     = ~ss_n_s;
      tx_ready = ~hold_full;
   end

   // Deselect is checked before the sclk strobes so it wins over a coincident edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt      <= '0;
         rx_sh        <= '0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         frame_err    <= 1'b0;
         tx_sh        <= '0;
         hold         <= '0;
         hold_full    <= 1'b0;
         presel       <= '0;
         load_pending <= 1'b0;
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;

         if (tx_valid && !hold_full) begin
            hold      <= tx_data;
            hold_full <= 1'b1;
         end

         case (state)
            SPI_IDLE: begin
               bit_cnt      <= '0;
               load_pending <= 1'b0;
               if (ss_fall) begin
                  tx_sh     <= pick_tx(hold_full, hold);
                  hold_full <= 1'b0;
               end
            end
            SPI_ACTIVE: begin
               if (ss_n_s) begin
                  frame_err    <= (bit_cnt != '0);
                  bit_cnt      <= '0;
                  load_pending <= 1'b0;
               end else if (sclk_rise) begin
                  rx_sh <= {rx_sh[DW-2:0], mosi_s};
                  if (bit_cnt == LAST_BIT) begin
                     rx_data      <= {rx_sh[DW-2:0], mosi_s};
                     rx_valid     <= 1'b1;
                     bit_cnt      <= '0;
                     presel       <= pick_tx(hold_full, hold);
                     hold_full    <= 1'b0;
                     load_pending <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + CW'(1);
                  end
               end else if (sclk_fall) begin
                  if (load_pending) begin
                     tx_sh        <= presel;
                     load_pending <= 1'b0;
                  end else begin
                     tx_sh <= {tx_sh[DW-2:0], 1'b0};
                  end
               end
            end
            default: begin
               bit_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: a behavioural SPI master drives frames,
// expected rx bytes go through a scoreboard queue popped on every rx_valid.
module tb_spi_slave_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic       ss_n;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       frame_err;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;
   int rx_cnt      = 0;
   int fe_cnt      = 0;

   logic [7:0] rx_q[$];
   logic [7:0] got;

   spi_slave_rx dut (
      .clk       (clk),
      .rst       (rst),
      .ss_n      (ss_n),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .miso_oe   (miso_oe),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard side: every rx strobe must match the oldest outstanding byte.
   always @(negedge clk) begin
      if (!rst) begin
         if (rx_valid) begin
            rx_cnt++;
            if (rx_q.size() == 0) begin
               vectors++;
               assert (1'b0) else begin
                  miscompares++;
                  $error("[TB] FAIL rx_unexpected: observed %0h expected none", rx_data);
               end
            end else begin
               check_output("rx_data", 32'(rx_data), 32'(rx_q.pop_front()));
            end
         end
         if (frame_err) fe_cnt++;
      end
   end

   initial begin
      #2ms;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_tx(input logic [7:0] b);
      @(negedge clk);
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic select_slave();
      ss_n = 1'b0;
      tick(4);
   endtask

   task automatic deselect_slave();
      tick(2);
      ss_n = 1'b1;
      tick(6);
   endtask

   // Mode 0 master, sclk = clk/4; miso is taken late in the high phase because
   // the slave only updates it a few clk after the synchronised fall.
   task automatic spi_byte(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
      mi = '0;
      for (int i = 0; i < nbits; i++) begin
         mosi = mo[7-i];
         tick(2);
         sclk = 1'b1;
         tick(2);
         mi[7-i] = miso;
         sclk = 1'b0;
      end
   endtask

   task automatic wait_rx_drain(input string tag);
      for (int i = 0; i < 40 && rx_q.size() != 0; i++) tick(1);
      check_output(tag, 32'(rx_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      tx_data = '0; tx_valid = 1'b0;
      tick(3);

      check_output("rst_miso",      32'(miso),      32'd0);
      check_output("rst_miso_oe",   32'(miso_oe),   32'd0);
      check_output("rst_tx_ready",  32'(tx_ready),  32'd1);
      check_output("rst_rx_data",   32'(rx_data),   32'h00);
      check_output("rst_rx_valid",  32'(rx_valid),  32'd0);
      check_output("rst_frame_err", 32'(frame_err), 32'd0);
      check_output("rst_busy",      32'(busy),      32'd0);
      rst = 1'b0;
      tick(2);

      // Reset in the middle of a byte
      select_slave();
      spi_byte(8'hB7, 4, got);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; ss_n = 1'b1;
      check_output("midrst_miso_oe",  32'(miso_oe),  32'd0);
      check_output("midrst_busy",     32'(busy),     32'd0);
      check_output("midrst_tx_ready", 32'(tx_ready), 32'd1);
      check_output("midrst_rx_data",  32'(rx_data),  32'h00);
      tick(6);
      check_output("midrst_no_fe", 32'(fe_cnt), 32'd0);
      check_output("midrst_no_rx", 32'(rx_cnt), 32'd0);
      select_slave();
      rx_q.push_back(8'h3C);
      spi_byte(8'h3C, 8, got);
      check_output("midrst_miso_idle", 32'(got), 32'h00);
      wait_rx_drain("midrst_rx_drain");
      deselect_slave();

      // Single byte with a preloaded reply
      load_tx(8'h5A);
      check_output("single_tx_ready_low", 32'(tx_ready), 32'd0);
      select_slave();
      check_output("single_tx_ready_back", 32'(tx_ready), 32'd1);
      check_output("single_miso_oe",       32'(miso_oe),  32'd1);
      check_output("single_busy",          32'(busy),     32'd1);
      rx_q.push_back(8'hA5);
      spi_byte(8'hA5, 8, got);
      check_output("single_miso_byte", 32'(got), 32'h5A);
      wait_rx_drain("single_rx_drain");
      deselect_slave();
      check_output("single_miso_oe_off", 32'(miso_oe), 32'd0);
      check_output("single_no_fe",       32'(fe_cnt),  32'd0);
      check_output("single_rx_count",    32'(rx_cnt),  32'd2);

      // Back-to-back bytes in one frame, second reply loaded while busy
      load_tx(8'hC3);
      select_slave();
      for (int i = 0; i < 10 && tx_ready !== 1'b1; i++) tick(1);
      check_output("b2b_tx_ready", 32'(tx_ready), 32'd1);
      load_tx(8'h3C);
      rx_q.push_back(8'h01);
      spi_byte(8'h01, 8, got);
      check_output("b2b_miso_0", 32'(got), 32'hC3);
      rx_q.push_back(8'h80);
      spi_byte(8'h80, 8, got);
      check_output("b2b_miso_1", 32'(got), 32'h3C);
      rx_q.push_back(8'hFF);
      spi_byte(8'hFF, 8, got);
      check_output("b2b_miso_2", 32'(got), 32'h00);
      wait_rx_drain("b2b_rx_drain");
      deselect_slave();
      check_output("b2b_rx_count", 32'(rx_cnt), 32'd5);
      check_output("b2b_rx_data",  32'(rx_data), 32'hFF);

      // Abort after five bits
      select_slave();
      spi_byte(8'hF0, 5, got);
      deselect_slave();
      check_output("abort_fe_count", 32'(fe_cnt),  32'd1);
      check_output("abort_no_rx",    32'(rx_cnt),  32'd5);
      check_output("abort_rx_data",  32'(rx_data), 32'hFF);
      check_output("abort_miso_oe",  32'(miso_oe), 32'd0);

      // Clock noise while deselected, then a clean byte proves the counter stayed at 0
      for (int i = 0; i < 8; i++) begin
         mosi = 1'($urandom_range(0, 1));
         tick(2);
         sclk = 1'b1;
         tick(2);
         sclk = 1'b0;
      end
      tick(4);
      check_output("noise_miso_oe", 32'(miso_oe), 32'd0);
      check_output("noise_busy",    32'(busy),    32'd0);
      check_output("noise_no_rx",   32'(rx_cnt),  32'd5);
      select_slave();
      rx_q.push_back(8'h96);
      spi_byte(8'h96, 8, got);
      wait_rx_drain("noise_rx_drain");
      deselect_slave();
      check_output("noise_rx_data", 32'(rx_data), 32'h96);
      check_output("final_fe_count", 32'(fe_cnt), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
